// File: rtl/bp_be_fe_queue_buffer.sv
// ----------------------------------------------------------------------------
// bp_be_fe_queue_buffer
//
// Circular buffer between the FE fetch queue output and BE issue. It accepts
// fetch/exception messages from the FE, presents them in order to issue, and
// flushes them on a redirect or pipeline clear. Ready never depends on the
// incoming valid, because the FE derives its valid from our ready.
//
// Optional feature macro: BP_FE_QUEUE_ROLL_EN
//   Defined   : dequeued entries stay allocated until committed; roll_i
//               re-presents every issued but uncommitted entry.
//   Undefined : a dequeue frees its entry at once; commit_i/roll_i are unused.
//
// Parameters
//   els_p    number of entries (power of 2, >= 2)
//   width_p  message width
//
// Ports
//   clk_i             clock, rising edge
//   reset_n_i         asynchronous active-low reset
//   fe_queue_i        message from the FE
//   fe_queue_v_i      enqueue valid
//   fe_queue_ready_o  space available (not full)
//   fe_queue_o        head message (zero while empty)
//   fe_queue_v_o      head valid (not empty)
//   fe_queue_yumi_i   issue consumed the head
//   clr_i             flush all entries; overrides every other input
//   commit_i          retire the oldest issued entry (roll build only)
//   roll_i            re-present uncommitted entries (roll build only)
//   count_o           occupied (not yet freed) entries
// ----------------------------------------------------------------------------
module bp_be_fe_queue_buffer #(
    parameter int unsigned els_p   = 8,
    parameter int unsigned width_p = 128
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [width_p-1:0]         fe_queue_i,
    input  logic                       fe_queue_v_i,
    output logic                       fe_queue_ready_o,
    output logic [width_p-1:0]         fe_queue_o,
    output logic                       fe_queue_v_o,
    input  logic                       fe_queue_yumi_i,
    input  logic                       clr_i,
    input  logic                       commit_i,
    input  logic                       roll_i,
    output logic [$clog2(els_p+1)-1:0] count_o
);

    localparam int unsigned IdxW = $clog2(els_p);
    localparam int unsigned PtrW = IdxW + 1;
    localparam int unsigned CntW = $clog2(els_p + 1);

    // Pointers carry one wrap bit above the index so full and empty differ.
    logic [PtrW-1:0]    r_wptr;
    logic [PtrW-1:0]    r_rptr;
    logic [PtrW-1:0]    w_wptr_n;
    logic [PtrW-1:0]    w_rptr_n;
    logic [PtrW-1:0]    w_fptr;
    logic [PtrW-1:0]    w_count;
    logic [IdxW-1:0]    w_widx;
    logic [IdxW-1:0]    w_ridx;
    logic               w_empty;
    logic               w_full;
    logic               w_enq;
    logic               w_deq;

    logic [width_p-1:0] r_mem [els_p];

    assign w_widx = r_wptr[IdxW-1:0];
    assign w_ridx = r_rptr[IdxW-1:0];

`ifdef BP_FE_QUEUE_ROLL_EN
    logic [PtrW-1:0] r_cptr;
    logic [PtrW-1:0] w_cptr_n;
    logic            w_commit;

    // Entries are only freed once committed, so fullness is measured from cptr.
    assign w_fptr   = r_cptr;
    assign w_commit = commit_i & (r_cptr != r_rptr);
`else
    logic w_unused_roll;

    assign w_fptr        = r_rptr;
    assign w_unused_roll = commit_i ^ roll_i;
`endif

    assign w_empty = (r_rptr == r_wptr);
    assign w_full  = (w_fptr[IdxW-1:0] == r_wptr[IdxW-1:0]) && (w_fptr[IdxW] != r_wptr[IdxW]);

    assign fe_queue_ready_o = ~w_full;
    assign fe_queue_v_o     = ~w_empty;
    assign fe_queue_o       = w_empty ? '0 : r_mem[w_ridx];

    assign w_enq = fe_queue_v_i & ~w_full & ~clr_i;
    assign w_deq = fe_queue_yumi_i & ~w_empty;

    // Power-of-two depth: a plain increment wraps the index and toggles the MSB.
    always_comb begin
        w_wptr_n = r_wptr;
        w_rptr_n = r_rptr;
`ifdef BP_FE_QUEUE_ROLL_EN
        w_cptr_n = r_cptr;
`endif
        if (clr_i) begin
            w_wptr_n = '0;
            w_rptr_n = '0;
`ifdef BP_FE_QUEUE_ROLL_EN
            w_cptr_n = '0;
`endif
        end else begin
            if (w_enq) begin
                w_wptr_n = r_wptr + PtrW'(1);
            end
`ifdef BP_FE_QUEUE_ROLL_EN
            if (w_commit) begin
                w_cptr_n = r_cptr + PtrW'(1);
            end
            // Roll uses the post-commit cptr and takes priority over yumi.
            if (roll_i) begin
                w_rptr_n = w_cptr_n;
            end else if (w_deq) begin
                w_rptr_n = r_rptr + PtrW'(1);
            end
`else
            if (w_deq) begin
                w_rptr_n = r_rptr + PtrW'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_wptr <= w_wptr_n;
            r_rptr <= w_rptr_n;
        end
    end

`ifdef BP_FE_QUEUE_ROLL_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cptr <= '0;
        end else begin
            r_cptr <= w_cptr_n;
        end
    end
`endif

    // Storage is not reset; stale contents are hidden by the pointers.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_mem[w_widx] <= fe_queue_i;
        end
    end

    // Modulo 2*els_p difference; equals els_p exactly when full.
    assign w_count = r_wptr - w_fptr;
    assign count_o = CntW'(w_count);

    a_no_yumi_when_empty : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(fe_queue_yumi_i && w_empty && !clr_i));

`ifdef BP_FE_QUEUE_ROLL_EN
    a_no_commit_past_issue : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(commit_i && (r_cptr == r_rptr) && !clr_i));
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_buffer.sv
module tb_bp_be_fe_queue_buffer;

    localparam int unsigned Els = 8;
    localparam int unsigned W   = 128;
`ifdef BP_FE_QUEUE_ROLL_EN
    localparam bit RollEn = 1'b1;
`else
    localparam bit RollEn = 1'b0;
`endif

    logic         clk;
    logic         reset_n;
    logic [W-1:0] fe_in;
    logic         fe_v_in;
    logic         fe_ready;
    logic [W-1:0] fe_out;
    logic         fe_v_out;
    logic         yumi;
    logic         clr;
    logic         commit;
    logic         roll;
    logic [3:0]   count;

    int n_checks = 0;
    int n_errors = 0;

    // Model: sb holds entries not yet issued, issued holds issued-uncommitted ones.
    logic [W-1:0] sb[$];
    logic [W-1:0] issued[$];

    bp_be_fe_queue_buffer #(.els_p(Els), .width_p(W)) dut (
        .clk_i            (clk),
        .reset_n_i        (reset_n),
        .fe_queue_i       (fe_in),
        .fe_queue_v_i     (fe_v_in),
        .fe_queue_ready_o (fe_ready),
        .fe_queue_o       (fe_out),
        .fe_queue_v_o     (fe_v_out),
        .fe_queue_yumi_i  (yumi),
        .clr_i            (clr),
        .commit_i         (commit),
        .roll_i           (roll),
        .count_o          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge: check outputs against the model, apply one cycle of
    // stimulus, advance the model to the post-edge state, then wait for the next fall.
    task automatic drive(input logic e, input logic [W-1:0] d, input logic y,
                         input logic c = 1'b0, input logic cm = 1'b0, input logic rl = 1'b0);
        int occ;
        logic [W-1:0] h;
        occ = sb.size() + issued.size();
        check_eq("ready", fe_ready, occ != Els);
        check_eq("valid", fe_v_out, sb.size() != 0);
        check_eq("count", count, occ);
        if (sb.size() != 0) check_eq("head", fe_out, sb[0]);
        fe_v_in = e;
        fe_in   = d;
        yumi    = y;
        clr     = c;
        commit  = cm;
        roll    = rl;
        if (c) begin
            sb.delete();
            issued.delete();
        end else begin
            if (cm && issued.size() != 0) void'(issued.pop_front());
            if (rl) begin
                sb = {issued, sb};
                issued.delete();
            end else if (y && sb.size() != 0) begin
                h = sb.pop_front();
                if (RollEn) issued.push_back(h);
            end
            if (e && occ != Els) sb.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic flush();
        drive(1'b0, '0, 1'b0, 1'b1);
        idle();
    endtask

    initial begin
        reset_n = 1'b1;
        fe_in   = '0;
        fe_v_in = 1'b0;
        yumi    = 1'b0;
        clr     = 1'b0;
        commit  = 1'b0;
        roll    = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check_eq("rst_ready", fe_ready, 1);
        check_eq("rst_valid", fe_v_out, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_data", fe_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: three back-to-back enqueues, head visible one cycle after A
        drive(1'b1, 128'hA, 1'b0);
        check_eq("t1_valid_after_a", fe_v_out, 1);
        check_eq("t1_head_a", fe_out, 128'hA);
        drive(1'b1, 128'hB, 1'b0);
        drive(1'b1, 128'hC, 1'b0);
        check_eq("t1_count3", count, 3);
        while (sb.size() != 0) drive(1'b0, '0, 1'b1);
        flush();

        // 2: fill, refused ninth write, one dequeue
        for (int i = 0; i < Els; i++) drive(1'b1, W'(32'h200 + i), 1'b0);
        check_eq("t2_ready_full", fe_ready, 0);
        check_eq("t2_count_full", count, Els);
        drive(1'b1, 128'hDEAD, 1'b0);
        drive(1'b0, '0, 1'b1);
        if (!RollEn) begin
            check_eq("t2_ready_after_yumi", fe_ready, 1);
            check_eq("t2_count_after_yumi", count, Els - 1);
        end
        while (sb.size() != 0) drive(1'b0, '0, 1'b1);
        flush();

        // 3: steady enq+deq pairs across the index wrap
        for (int i = 0; i < 3; i++) drive(1'b1, W'(32'h300 + i), 1'b0);
        for (int i = 0; i < 20; i++)
            drive(1'b1, W'(32'h310 + i), 1'b1, 1'b0, RollEn && issued.size() != 0);
        idle();
        flush();

        // 4: clear wins over simultaneous enqueue and yumi
        for (int i = 0; i < 5; i++) drive(1'b1, W'(32'h400 + i), 1'b0);
        drive(1'b1, 128'h4BAD, 1'b1, 1'b1);
        check_eq("t4_valid", fe_v_out, 0);
        check_eq("t4_count", count, 0);
        check_eq("t4_ready", fe_ready, 1);
        drive(1'b1, 128'h4001, 1'b0);
        check_eq("t4_head_new", fe_out, 128'h4001);
        idle();
        flush();

`ifdef BP_FE_QUEUE_ROLL_EN
        // 5: commit one, roll the rest back
        for (int i = 0; i < 4; i++) drive(1'b1, W'(32'hA + i), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_eq("t5_head_b", fe_out, 128'hB);
        check_eq("t5_count3", count, 3);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("t5_head_c", fe_out, 128'hC);
        idle();
        flush();

        // 6: issued-but-uncommitted entries keep the queue full
        for (int i = 0; i < Els; i++) drive(1'b1, W'(32'h600 + i), 1'b0);
        for (int i = 0; i < Els; i++) drive(1'b0, '0, 1'b1);
        check_eq("t6_ready_held", fe_ready, 0);
        check_eq("t6_valid_none", fe_v_out, 0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_eq("t6_ready_commit", fe_ready, 1);
        idle();
        flush();
`endif

        // 7: asynchronous reset between clock edges
        drive(1'b1, 128'h700, 1'b0);
        drive(1'b1, 128'h701, 1'b0);
        fe_v_in = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq("t7_valid", fe_v_out, 0);
        check_eq("t7_ready", fe_ready, 1);
        check_eq("t7_count", count, 0);
        sb.delete();
        issued.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive(1'b1, 128'h702, 1'b0);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
